// File: rtl/wb_write_sequencer.sv
// Register write-back sequencer: turns one accepted request into zero, one or two
// register-file writes over a single write port, with retire pulse and pending mask.
module wb_write_sequencer #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              retire,
    output logic [14:0]       pending_mask,
    output logic [31:0]       retire_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W1   = 2'd1;
    localparam logic [1:0] ST_W2   = 2'd2;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] IC_POPQ  = 4'hB;

    logic [1:0]        state;
    logic [3:0]        icode_p0;
    logic [3:0]        ra_p0;
    logic [3:0]        rb_p0;
    logic [DATA_W-1:0] vale_p0;
    logic [DATA_W-1:0] valm_p0;

    logic              first_vld;
    logic [3:0]        first_addr;
    logic [DATA_W-1:0] first_data;
    logic              two_writes;

    // Register 0xF falls off the top of the 15-bit mask, so it never marks pending.
    function automatic logic [14:0] reg_bit(input logic [3:0] addr);
        logic [15:0] one_hot;
        one_hot = 16'd1 << addr;
        return one_hot[14:0];
    endfunction

    always_comb begin
        first_vld  = 1'b0;
        first_addr = REG_NONE;
        first_data = '0;
        case (icode_p0)
            4'h2, 4'h3, 4'h6: begin
                first_vld  = 1'b1;
                first_addr = rb_p0;
                first_data = vale_p0;
            end
            4'h5: begin
                first_vld  = 1'b1;
                first_addr = ra_p0;
                first_data = valm_p0;
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                first_vld  = 1'b1;
                first_addr = REG_RSP;
                first_data = vale_p0;
            end
            default: ;
        endcase
        two_writes = (icode_p0 == IC_POPQ);
    end

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        retire       = 1'b0;
        pending_mask = '0;
        case (state)
            ST_W1: begin
                wr_en        = first_vld && (first_addr != REG_NONE);
                wr_addr      = first_addr;
                wr_data      = first_data;
                retire       = !two_writes;
                pending_mask = (first_vld ? reg_bit(first_addr) : 15'd0)
                             | (two_writes ? reg_bit(ra_p0) : 15'd0);
            end
            ST_W2: begin
                wr_en        = (ra_p0 != REG_NONE);
                wr_addr      = ra_p0;
                wr_data      = valm_p0;
                retire       = 1'b1;
                pending_mask = reg_bit(ra_p0);
            end
            default: ;
        endcase
        // A reset cycle must not leak a write or retire of an aborted request.
        if (reset) begin
            wr_en        = 1'b0;
            retire       = 1'b0;
            pending_mask = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            icode_p0     <= '0;
            ra_p0        <= '0;
            rb_p0        <= '0;
            vale_p0      <= '0;
            valm_p0      <= '0;
            retire_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        icode_p0 <= icode;
                        ra_p0    <= rA;
                        rb_p0    <= rB;
                        vale_p0  <= valE;
                        valm_p0  <= valM;
                        state    <= ST_W1;
                    end
                end
                ST_W1:   state <= two_writes ? ST_W2 : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (retire) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: one task per scenario, hand-computed
// expectations for control outputs {in_ready, wr_en, retire, pending_mask} and write data.
module tb_wb_write_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        retire;
    logic [14:0] pending_mask;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    logic [17:0] ctl;
    logic [67:0] wdat;
    assign ctl  = {in_ready, wr_en, retire, pending_mask};
    assign wdat = {wr_addr, wr_data};

    wb_write_sequencer #(.DATA_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .icode        (icode),
        .rA           (rA),
        .rB           (rB),
        .valE         (valE),
        .valM         (valM),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .retire       (retire),
        .pending_mask (pending_mask),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic request(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] e, input logic [63:0] m);
        icode = ic; rA = a; rB = b; valE = e; valM = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; icode = 4'h3; rB = 4'h2; valE = 64'h5;
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (retire_count !== 32'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", retire_count);
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL reset_over_accept got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
    endtask

    task automatic test_irmovq();
        request(4'h3, 4'h0, 4'h2, 64'h55, 64'h0);
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0004}) begin
            errors++; $display("FAIL irmovq_ctl got=%h exp=%h", ctl, {1'b0, 1'b1, 1'b1, 15'h0004});
        end
        checks++;
        if (wdat !== {4'h2, 64'h55}) begin
            errors++; $display("FAIL irmovq_wdat got=%h exp=%h", wdat, {4'h2, 64'h55});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL irmovq_idle got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
        checks++;
        if (retire_count !== 32'd1) begin
            errors++; $display("FAIL irmovq_count got=%0d exp=1", retire_count);
        end
    endtask

    task automatic test_popq();
        request(4'hB, 4'h0, 4'hF, 64'h80, 64'h77);
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b0, 15'h0011}) begin
            errors++; $display("FAIL popq_w1_ctl got=%h exp=%h", ctl, {1'b0, 1'b1, 1'b0, 15'h0011});
        end
        checks++;
        if (wdat !== {4'h4, 64'h80}) begin
            errors++; $display("FAIL popq_w1_wdat got=%h exp=%h", wdat, {4'h4, 64'h80});
        end
        step();
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0001}) begin
            errors++; $display("FAIL popq_w2_ctl got=%h exp=%h", ctl, {1'b0, 1'b1, 1'b1, 15'h0001});
        end
        checks++;
        if (wdat !== {4'h0, 64'h77}) begin
            errors++; $display("FAIL popq_w2_wdat got=%h exp=%h", wdat, {4'h0, 64'h77});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL popq_idle got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
        checks++;
        if (retire_count !== 32'd2) begin
            errors++; $display("FAIL popq_count got=%0d exp=2", retire_count);
        end
    endtask

    task automatic test_popq_rsp();
        request(4'hB, 4'h4, 4'hF, 64'h88, 64'h99);
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b0, 15'h0010} || wdat !== {4'h4, 64'h88}) begin
            errors++; $display("FAIL poprsp_w1 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b0, 15'h0010}, {4'h4, 64'h88});
        end
        step();
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0010} || wdat !== {4'h4, 64'h99}) begin
            errors++; $display("FAIL poprsp_w2 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b1, 15'h0010}, {4'h4, 64'h99});
        end
        step();
        checks++;
        if (retire_count !== 32'd3) begin
            errors++; $display("FAIL poprsp_count got=%0d exp=3", retire_count);
        end
    endtask

    task automatic test_call();
        request(4'h8, 4'h7, 4'h9, 64'h1234, 64'h5678);
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0010} || wdat !== {4'h4, 64'h1234}) begin
            errors++; $display("FAIL call_w1 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b1, 15'h0010}, {4'h4, 64'h1234});
        end
        step();
        checks++;
        if (retire_count !== 32'd4) begin
            errors++; $display("FAIL call_count got=%0d exp=4", retire_count);
        end
    endtask

    task automatic test_suppress();
        do_reset();
        checks++;
        if (retire_count !== 32'd0) begin
            errors++; $display("FAIL supp_reset_count got=%0d exp=0", retire_count);
        end
        request(4'h6, 4'h1, 4'hF, 64'h1, 64'h0);
        checks++;
        if (ctl !== {1'b0, 1'b0, 1'b1, 15'h0}) begin
            errors++; $display("FAIL supp_opq_ctl got=%h exp=%h", ctl, {1'b0, 1'b0, 1'b1, 15'h0});
        end
        step();
        request(4'h1, 4'h2, 4'h3, 64'h2, 64'h3);
        checks++;
        if (ctl !== {1'b0, 1'b0, 1'b1, 15'h0}) begin
            errors++; $display("FAIL supp_nop_ctl got=%h exp=%h", ctl, {1'b0, 1'b0, 1'b1, 15'h0});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0} || retire_count !== 32'd2) begin
            errors++; $display("FAIL supp_end got=%h/%0d exp=%h/2", ctl, retire_count,
                               {1'b1, 1'b0, 1'b0, 15'h0});
        end
    endtask

    task automatic test_reset_in_w1();
        do_reset();
        request(4'hB, 4'h3, 4'hF, 64'hA, 64'hB);
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b0, 15'h0018}) begin
            errors++; $display("FAIL rstw1_pre got=%h exp=%h", ctl, {1'b0, 1'b1, 1'b0, 15'h0018});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== {1'b0, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL rstw1_forced got=%h exp=%h", ctl, {1'b0, 1'b0, 1'b0, 15'h0});
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0} || retire_count !== 32'd0) begin
            errors++; $display("FAIL rstw1_after got=%h/%0d exp=%h/0", ctl, retire_count,
                               {1'b1, 1'b0, 1'b0, 15'h0});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0} || retire_count !== 32'd0) begin
            errors++; $display("FAIL rstw1_no_w2 got=%h/%0d exp=%h/0", ctl, retire_count,
                               {1'b1, 1'b0, 1'b0, 15'h0});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        icode = 4'h3; rB = 4'h1; rA = 4'hF; valE = 64'h10; valM = 64'h0;
        in_valid = 1'b1;
        step();
        // Next request presented while busy must not disturb the current one.
        icode = 4'h5; rA = 4'h3; rB = 4'h7; valE = 64'hDEAD; valM = 64'h20;
        #1;
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0002} || wdat !== {4'h1, 64'h10}) begin
            errors++; $display("FAIL b2b_req1 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b1, 15'h0002}, {4'h1, 64'h10});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL b2b_gap1 got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
        step();
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0008} || wdat !== {4'h3, 64'h20}) begin
            errors++; $display("FAIL b2b_req2 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b1, 15'h0008}, {4'h3, 64'h20});
        end
        icode = 4'hB; rA = 4'h6; rB = 4'hF; valE = 64'h30; valM = 64'h40;
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
            errors++; $display("FAIL b2b_gap2 got=%h exp=%h", ctl, {1'b1, 1'b0, 1'b0, 15'h0});
        end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b0, 15'h0050} || wdat !== {4'h4, 64'h30}) begin
            errors++; $display("FAIL b2b_req3_w1 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b0, 15'h0050}, {4'h4, 64'h30});
        end
        step();
        checks++;
        if (ctl !== {1'b0, 1'b1, 1'b1, 15'h0040} || wdat !== {4'h6, 64'h40}) begin
            errors++; $display("FAIL b2b_req3_w2 got=%h/%h exp=%h/%h", ctl, wdat,
                               {1'b0, 1'b1, 1'b1, 15'h0040}, {4'h6, 64'h40});
        end
        step();
        checks++;
        if (ctl !== {1'b1, 1'b0, 1'b0, 15'h0} || retire_count !== 32'd3) begin
            errors++; $display("FAIL b2b_end got=%h/%0d exp=%h/3", ctl, retire_count,
                               {1'b1, 1'b0, 1'b0, 15'h0});
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        icode = '0; rA = '0; rB = '0; valE = '0; valM = '0;
        test_reset();
        test_irmovq();
        test_popq();
        test_popq_rsp();
        test_call();
        test_suppress();
        test_reset_in_w1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1, "timeout");
    end

endmodule
